pico_port_bridge: RTL

Parametrised I/O bridge between the KCPSM6 (PicoBlaze) port bus and up to 15 peripheral channels (RTC, VGA, keyboard, sound, …). Decodes `port_id` into per-channel select, registers the read-data multiplexer, and turns write/read strobes into per-channel pulses of programmable length for slow peripherals. An optional status port reports bridge activity and write overruns. It sits between the `pico` core and the peripheral controllers and generalises the fixed four-peripheral port decoder.

---
 rtl/pico_port_bridge_if.sv | 37 +++
 rtl/pico_port_bridge.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pico_port_bridge_if.sv
// ============================================================================
// Module      : pico_port_bridge_if
// Description : KCPSM6 port bus plus per-channel peripheral signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pico_port_bridge_if #(
    parameter int NUM_CH = 4
);
    logic [7:0]          port_id;
    logic [7:0]          out_port;
    logic                write_strobe;
    logic                k_write_strobe;
    logic                read_strobe;
    logic [7:0]          in_port;
    logic [8*NUM_CH-1:0] ch_rdata;
    logic [NUM_CH-1:0]   ch_sel;
    logic [NUM_CH-1:0]   ch_wr;
    logic [NUM_CH-1:0]   ch_rd;
    logic [7:0]          wr_data;
    logic [3:0]          dir;
    logic                busy;

    // Processor and peripheral side driving the bridge
    modport master (
        output port_id, out_port, write_strobe, k_write_strobe, read_strobe, ch_rdata,
        input  in_port, ch_sel, ch_wr, ch_rd, wr_data, dir, busy
    );

    modport slave (
        input  port_id, out_port, write_strobe, k_write_strobe, read_strobe, ch_rdata,
        output in_port, ch_sel, ch_wr, ch_rd, wr_data, dir, busy
    );
endinterface

`default_nettype wire

// File: rtl/pico_port_bridge.sv
// ============================================================================
// Module      : pico_port_bridge
// Description : KCPSM6 port decoder, registered read mux and stretched
//               per-channel write pulses. Define PORT_BRIDGE_STATUS_EN to add
//               the status port at 8'hFF with a write-overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pico_port_bridge #(
    parameter int NUM_CH     = 4,
    parameter int WR_STRETCH = 1
) (
    input  wire logic        clk,
    input  wire logic        kcpsm6_reset,
    pico_port_bridge_if.slave bus
);
    localparam logic [0:0] c_st_idle      = 1'b0;
    localparam logic [0:0] c_st_stretch   = 1'b1;
    localparam logic [4:0] c_num_ch       = 5'(NUM_CH);
    localparam logic [7:0] c_stretch_load = 8'(WR_STRETCH - 1);
    localparam logic [7:0] c_status_port  = 8'hFF;

    logic [3:0]        w_idx;
    logic              w_hit;
    logic [NUM_CH-1:0] w_sel;
    logic              w_wr;
    logic [7:0]        w_status_data;
    logic [7:0]        w_rdata;

    logic [7:0]        r_in_port;
    logic [NUM_CH-1:0] r_ch_sel;
    logic [NUM_CH-1:0] r_ch_rd;
    logic [0:0]        r_state;
    logic [7:0]        r_cnt;
    logic [NUM_CH-1:0] r_ch_wr;
    logic [7:0]        r_wr_data;
    logic [3:0]        r_dir;

    assign w_idx = bus.port_id[7:4];
    assign w_hit = ({1'b0, w_idx} < c_num_ch) && (bus.port_id != c_status_port);
    assign w_wr  = (bus.write_strobe || bus.k_write_strobe) && w_hit;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_sel
        assign w_sel[c] = w_hit && (w_idx == 4'(c));
    end

`ifdef PORT_BRIDGE_STATUS_EN
    logic r_overrun;
    logic w_overrun_set;

    // A reload with zero count left is a seamless back-to-back write, not an overrun
    assign w_overrun_set = w_wr && (r_state == c_st_stretch) && (r_cnt != 8'd0);
    assign w_status_data = (bus.port_id == c_status_port) ?
                           {r_overrun, (r_state == c_st_stretch), 2'b00, 4'(NUM_CH)} : 8'h00;

    always_ff @(posedge clk or negedge kcpsm6_reset) begin
        if (!kcpsm6_reset) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end else if (bus.read_strobe && (bus.port_id == c_status_port)) begin
            r_overrun <= 1'b0;
        end
    end
`else
    assign w_status_data = 8'h00;
`endif

    always_comb begin
        w_rdata = w_status_data;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_sel[c]) begin
                w_rdata = bus.ch_rdata[8*c +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge kcpsm6_reset) begin
        if (!kcpsm6_reset) begin
            r_in_port <= 8'h00;
            r_ch_sel  <= '0;
            r_ch_rd   <= '0;
        end else begin
            r_in_port <= w_rdata;
            r_ch_sel  <= w_sel;
            r_ch_rd   <= bus.read_strobe ? w_sel : '0;
        end
    end

    always_ff @(posedge clk or negedge kcpsm6_reset) begin
        if (!kcpsm6_reset) begin
            r_state   <= c_st_idle;
            r_cnt     <= 8'd0;
            r_ch_wr   <= '0;
            r_wr_data <= 8'h00;
            r_dir     <= 4'h0;
        end else if (w_wr) begin
            // New hit write always restarts the pulse, from either state
            r_state   <= c_st_stretch;
            r_cnt     <= c_stretch_load;
            r_ch_wr   <= w_sel;
            r_wr_data <= bus.out_port;
            r_dir     <= bus.port_id[3:0];
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_state <= c_st_idle;
                end
                c_st_stretch: begin
                    if (r_cnt == 8'd0) begin
                        r_ch_wr <= '0;
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.in_port = r_in_port;
    assign bus.ch_sel  = r_ch_sel;
    assign bus.ch_rd   = r_ch_rd;
    assign bus.ch_wr   = r_ch_wr;
    assign bus.wr_data = r_wr_data;
    assign bus.dir     = r_dir;
    assign bus.busy    = (r_state == c_st_stretch);

endmodule

`default_nettype wire
